text_ram_writer: RTL
====================

Name: text_ram_writer

Overview:
- Write-side controller for the character RAM feeding the text-mode VGA pipeline (char RAM -> font ROM -> rgb).
- Accepts a byte stream over a valid/ready handshake and interprets printable characters and a small set of control codes.
- Owns the cursor and sequences every write into the RAM write port, including the full-screen clear after reset and on request.
- Runs in the pixel clock domain. Its write port outputs connect directly to the RAM's wclk-side inputs.

Parameters:
- COLS, 80, characters per row (1..2^COL_W).
- ROWS, 60, text rows (1..2^ROW_W).
- COL_W, 7, column index width.
- ROW_W, 6, row index width.
- CLEAR_CHAR, 8'h20, fill byte used for clears.

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept s_data this cycle.
- s_data  in  8  input byte.
- clear_req  in  1  single-cycle request for a full-screen clear.
- busy  out  1  a clear sequence is in progress.
- ram_waddr  out  ROW_W+COL_W  RAM write address {row, col} (concatenation, not row*COLS+col).
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- cursor_col  out  COL_W  current cursor column.
- cursor_row  out  ROW_W  current cursor row.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - While rst_n=0: state=CLEAR with the clear counters at (0,0); ram_we=0, ram_waddr=0, ram_wdata=0; cursor=(0,0); s_ready=0; busy=1.
- State IDLE:
  - s_ready = 1 when state is IDLE and clear_req=0 (combinational).
  - A byte is accepted when s_valid & s_ready.
- Printable bytes (0x20..0x7E):
  - Cycle after acceptance: ram_we=1, ram_waddr={cursor_row,cursor_col} (cursor value at accept time), ram_wdata=byte.
  - The cursor updates on the same edge: col+1. If col==COLS-1, the cursor goes to col=0 and row advances.
- Control bytes:
  - 0x0D (CR): col=0.
  - 0x0A (LF): row advances, col unchanged.
  - 0x08 (BS): col-1 if col>0, else no change. No write.
  - 0x0C (FF): enter CLEAR, identical to clear_req.
  - Any other byte: accepted and discarded. No write, no cursor change.
- Row advance: row+1; ROWS-1 wraps to 0. There is no scrolling.
- ram_we is registered: it pulses for exactly 1 cycle per printable byte and is 0 otherwise in IDLE.
- Throughput: one byte per cycle sustained in IDLE.
- clear_req in IDLE: enter CLEAR and force s_ready=0 that cycle. clear_req wins over a simultaneous s_valid; that byte is not accepted.
- State CLEAR:
  - busy=1, s_ready=0.
  - Writes CLEAR_CHAR one address per cycle, row-major: col 0..COLS-1 within each row, rows 0..ROWS-1. That is COLS*ROWS consecutive ram_we cycles.
  - The first write appears the cycle after entry.
  - After the last address ({ROWS-1,COLS-1}): cursor=(0,0), next cycle is IDLE, busy=0.
  - clear_req during CLEAR is ignored; no restart.
  - Addresses with col>=COLS are never written.
- Reset mid-operation (any state): returns to the reset values above and restarts the clear from (0,0).

Optional Feature:
- Macro: TEXT_LINE_CLEAR_EN.
- When defined:
  - Every row advance (LF or column wrap) enters state LINECLR.
  - LINECLR writes CLEAR_CHAR to {new_row, 0..COLS-1}: COLS cycles with s_ready=0 and busy=1, then returns to IDLE.
  - On a column wrap, the printable byte's own write completes first. Its ram_we cycle precedes the first LINECLR write.
  - clear_req arriving during LINECLR is held and honoured on return to IDLE.
- When undefined: no LINECLR state; row advance only moves the cursor.

Test Plan:
1. Reset: rst_n low 3 cycles, then high.
   -> 4800 consecutive ram_we pulses, wdata=0x20, addresses 0,1..79,128..; last address {59,79}=7631. Then busy=0, s_ready=1, cursor (0,0).
2. After clear, send 0x41 (A).
   -> Next cycle ram_we=1, waddr=0, wdata=0x41; cursor_col=1.
   -> Then send 0x0D, 0x0A: no ram_we; cursor (0,1).
3. Send 80 x 0x58 back-to-back with s_valid held.
   -> 80 writes at addresses 128..207 on consecutive cycles; final cursor (0,2).
   -> With TEXT_LINE_CLEAR_EN: 80 additional writes of 0x20 at addresses 256..335, with s_ready=0 throughout.
4. Cursor at (5,59), send 0x0A.
   -> Cursor (5,0). Send 0x08 x6: cursor col 4,3,2,1,0,0. No writes.
5. clear_req and s_valid (0x42) asserted in the same IDLE cycle.
   -> s_ready=0, byte not accepted, CLEAR runs 4800 cycles.
   -> A clear_req pulse mid-clear does not extend it. 0x42, still held, is accepted only after busy=0.
6. Drop rst_n during CLEAR at write #1000.
   -> ram_we=0 immediately. After release, the clear restarts at address 0 and runs the full 4800 writes.

Source files
------------

// File: rtl/text_ram_writer.sv
// Write-side controller for the text-mode character RAM: byte stream in, cursor + RAM writes out.
// Optional TEXT_LINE_CLEAR_EN: every row advance blanks the new row before accepting more input.
module text_ram_writer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter int         COL_W      = 7,
    parameter int         ROW_W      = 6,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   clear_req,
    output logic                   busy,
    output logic [ROW_W+COL_W-1:0] ram_waddr,
    output logic [7:0]             ram_wdata,
    output logic                   ram_we,
    output logic [COL_W-1:0]       cursor_col,
    output logic [ROW_W-1:0]       cursor_row
);

    typedef enum logic [1:0] {IDLE, CLEAR, LINECLR} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           state;
    logic [COL_W-1:0] clr_col;
    logic [ROW_W-1:0] clr_row;
    logic [ROW_W-1:0] row_inc;
    logic             printable;
`ifdef TEXT_LINE_CLEAR_EN
    logic             clr_pend;
`endif

    assign s_ready   = (state == IDLE) && !clear_req;
    assign busy      = (state != IDLE);
    assign row_inc   = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
    assign printable = (s_data >= 8'h20) && (s_data <= 8'h7E);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_col    <= '0;
            clr_row    <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
`ifdef TEXT_LINE_CLEAR_EN
            clr_pend   <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_col <= '0;
                        clr_row <= '0;
                    end else if (s_valid) begin
                        if (printable) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= {cursor_row, cursor_col};
                            ram_wdata <= s_data;
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= '0;
                                cursor_row <= row_inc;
`ifdef TEXT_LINE_CLEAR_EN
                                state   <= LINECLR;
                                clr_col <= '0;
`endif
                            end else begin
                                cursor_col <= cursor_col + 1'b1;
                            end
                        end else begin
                            case (s_data)
                                8'h0D: cursor_col <= '0;
                                8'h0A: begin
                                    cursor_row <= row_inc;
`ifdef TEXT_LINE_CLEAR_EN
                                    state   <= LINECLR;
                                    clr_col <= '0;
`endif
                                end
                                8'h08: if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                                8'h0C: begin
                                    state   <= CLEAR;
                                    clr_col <= '0;
                                    clr_row <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    ram_we    <= 1'b1;
                    ram_waddr <= {clr_row, clr_col};
                    ram_wdata <= CLEAR_CHAR;
                    if (clr_col == LAST_COL) begin
                        clr_col <= '0;
                        if (clr_row == LAST_ROW) begin
                            clr_row    <= '0;
                            state      <= IDLE;
                            cursor_col <= '0;
                            cursor_row <= '0;
                        end else begin
                            clr_row <= clr_row + 1'b1;
                        end
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
`ifdef TEXT_LINE_CLEAR_EN
                LINECLR: begin
                    // cursor_row already points at the new row; no input is taken here
                    ram_we    <= 1'b1;
                    ram_waddr <= {cursor_row, clr_col};
                    ram_wdata <= CLEAR_CHAR;
                    if (clear_req) clr_pend <= 1'b1;
                    if (clr_col == LAST_COL) begin
                        clr_col  <= '0;
                        clr_row  <= '0;
                        clr_pend <= 1'b0;
                        state    <= (clr_pend || clear_req) ? CLEAR : IDLE;
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
